// File: rtl/stream_demux_n.sv
// Registered 1-to-NCH valid/ready stream demultiplexer with addressed and round-robin routing.
// Each channel has a one-deep holding register, so a stalled lane never blocks traffic bound for another.
module stream_demux_n #(
  parameter int NCH  = 8,
  parameter int SELW = 3,
  parameter int DW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SELW-1:0]   in_sel,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic [SELW-1:0]   rr_ptr,
  output logic [7:0]        drop_cnt
);

  // One extra bit so that NCH == 2**SELW still compares correctly.
  localparam logic [SELW:0]   NCH_W = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);

  logic [SELW-1:0] tgt;
  logic            bad;
  logic [NCH-1:0]  tgt_hot;
  logic [NCH-1:0]  load;
  logic            stall;
  logic            accept;
  logic [DW-1:0]   data_q [NCH];

  assign tgt = mode ? rr_ptr : in_sel;
  assign bad = ~mode & ({1'b0, in_sel} >= NCH_W);

  // NOTE: every always_comb output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    tgt_hot = '0;
    for (int k = 0; k < NCH; k++) tgt_hot[k] = (tgt == SELW'(k));
  end

  // Only the targeted channel can stall the input; a draining channel can be refilled on the same edge.
  assign stall    = |(tgt_hot & out_valid & ~out_ready);
  assign in_ready = en & ~rst & (bad | ~stall);
  assign accept   = in_valid & in_ready;
  assign load     = (accept & ~bad) ? tgt_hot : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      rr_ptr    <= '0;
      drop_cnt  <= '0;
      // NOTE: the data registers are reset too, because out_data must read zero right after reset.
      for (int k = 0; k < NCH; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (load[k]) begin
          out_valid[k] <= 1'b1;
          data_q[k]    <= in_data;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
      if (accept && mode)
        rr_ptr <= (rr_ptr == LAST) ? '0 : rr_ptr + SELW'(1);
      if (accept && bad && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign out_data[g*DW +: DW] = data_q[g];
  end

endmodule
